// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier bus: widths, host FSM states and
// the signed reference product used to cross-check returned results.
package booth_pkg;

  localparam int BOOTH_W  = 8;
  localparam int BOOTH_PW = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_M,
    ST_LOAD_Q,
    ST_WAIT_DONE,
    ST_CAPT_LO,
    ST_RESP
  } booth_host_state_t;

  // Both operands are sign-extended to the product width, so the truncated
  // product is the exact two's-complement result.
  function automatic logic [BOOTH_PW-1:0] booth_ref_mul(
    input logic [BOOTH_W-1:0] a,
    input logic [BOOTH_W-1:0] b
  );
    logic signed [BOOTH_PW-1:0] ax;
    logic signed [BOOTH_PW-1:0] bx;
    ax = {{(BOOTH_PW-BOOTH_W){a[BOOTH_W-1]}}, a};
    bx = {{(BOOTH_PW-BOOTH_W){b[BOOTH_W-1]}}, b};
    return ax * bx;
  endfunction

endpackage

// File: rtl/booth_wdog.sv
// Watchdog up-counter: cleared before each wait, counts while enabled and
// flags the cycle on which it holds TIMEOUT-1.
module booth_wdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/booth_host.sv
// Initiator end of the Booth multiplier bus: loads M then Q, collects the
// two-byte product and returns it with timeout and self-check flags.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and once rsp_valid is high it and
// the response fields stay constant until the transfer completes.
module booth_host
  import booth_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter bit CHECK   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [BOOTH_W-1:0]  req_a,
  input  logic [BOOTH_W-1:0]  req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [BOOTH_PW-1:0] rsp_product,
  output logic                rsp_err,
  output logic                rsp_mismatch,
  output logic                mul_enable,
  output logic [BOOTH_W-1:0]  mul_inbus,
  input  logic                mul_done,
  input  logic [BOOTH_W-1:0]  mul_outbus
);

  booth_host_state_t state;
  booth_host_state_t state_next;

  logic [BOOTH_W-1:0]  a_q;
  logic [BOOTH_W-1:0]  b_q;
  logic [BOOTH_PW-1:0] prod_q;
  logic                err_q;
  logic                mism_q;
  logic                wd_tc;
  logic [BOOTH_PW-1:0] ref_prod;
  logic [BOOTH_PW-1:0] cap_prod;

  booth_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk(clk),
    .rst(rst),
    .clr(state == ST_LOAD_Q),
    .en (state == ST_WAIT_DONE),
    .tc (wd_tc)
  );

  assign ref_prod = booth_ref_mul(a_q, b_q);
  assign cap_prod = {prod_q[BOOTH_PW-1:BOOTH_W], mul_outbus};

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (req_valid) state_next = ST_LOAD_M;
      ST_LOAD_M:    state_next = ST_LOAD_Q;
      ST_LOAD_Q:    state_next = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (mul_done)   state_next = ST_CAPT_LO;
        else if (wd_tc) state_next = ST_RESP;
      end
      ST_CAPT_LO:   state_next = ST_RESP;
      ST_RESP:      if (rsp_ready) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Bus and handshake outputs are registered from the next state so every
  // port comes straight off a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      mul_enable <= 1'b0;
      mul_inbus  <= '0;
      a_q        <= '0;
      b_q        <= '0;
      prod_q     <= '0;
      err_q      <= 1'b0;
      mism_q     <= 1'b0;
    end else begin
      state      <= state_next;
      req_ready  <= (state_next == ST_IDLE);
      rsp_valid  <= (state_next == ST_RESP);
      mul_enable <= (state_next == ST_LOAD_M);
      case (state_next)
        ST_LOAD_M:               mul_inbus <= req_a;
        ST_LOAD_Q, ST_WAIT_DONE: mul_inbus <= b_q;
        default:                 mul_inbus <= '0;
      endcase

      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            a_q    <= req_a;
            b_q    <= req_b;
            prod_q <= '0;
            err_q  <= 1'b0;
            mism_q <= 1'b0;
          end
        end
        ST_WAIT_DONE: begin
          if (mul_done) begin
            prod_q[BOOTH_PW-1:BOOTH_W] <= mul_outbus;
          end else if (wd_tc) begin
            err_q  <= 1'b1;
            prod_q <= '0;
          end
        end
        ST_CAPT_LO: begin
          if (mul_done) begin
            prod_q[BOOTH_W-1:0] <= mul_outbus;
            mism_q              <= CHECK && (ref_prod != cap_prod);
          end else begin
            err_q  <= 1'b1;
            prod_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_product  = prod_q;
  assign rsp_err      = err_q;
  assign rsp_mismatch = mism_q;

endmodule

// File: tb/tb_booth_host.sv
// Directed bench for booth_host: the bench plays the multiplier responder,
// predicts each response from the operands and the responder behaviour.
module tb_booth_host;

  localparam int TO      = 8;
  localparam bit CHECK_P = 1'b1;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_a;
  logic [7:0]  req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_product;
  logic        rsp_err;
  logic        rsp_mismatch;
  logic        mul_enable;
  logic [7:0]  mul_inbus;
  logic        mul_done;
  logic [7:0]  mul_outbus;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];
  logic prev_en = 1'b0;

  booth_host #(
    .TIMEOUT(TO),
    .CHECK  (CHECK_P)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .rsp_err     (rsp_err),
    .rsp_mismatch(rsp_mismatch),
    .mul_enable  (mul_enable),
    .mul_inbus   (mul_inbus),
    .mul_done    (mul_done),
    .mul_outbus  (mul_outbus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: response fields against the predicted queue head
  always @(negedge clk) begin
    if (rst) begin
      prev_en = 1'b0;
    end else begin
      if (mul_enable) chk("enable_single_cycle", {31'd0, prev_en}, 32'd0);
      prev_en = mul_enable;
      if (rsp_valid) begin
        chk("rsp_expected", {31'd0, exp_q.size() != 0}, 32'd1);
        chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
        if (exp_q.size() != 0) begin
          chk("rsp_fields", {14'd0, rsp_err, rsp_mismatch, rsp_product}, {14'd0, exp_q[0]});
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // mode 0: correct product, 1: given hi/lo bytes, 2: no done, 3: one-cycle done
  task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int mode,
                         input logic [7:0] hi, input logic [7:0] lo,
                         input int dly, input int hold, input logic [15:0] lit_prod,
                         input logic lit_err, input logic lit_mism);
    int c;
    int p;
    int w;
    logic [15:0] prod;
    logic e;
    logic m;
    p = $signed(a) * $signed(b);
    case (mode)
      0:       begin prod = p[15:0]; e = 1'b0; end
      1:       begin prod = {hi, lo}; e = 1'b0; end
      default: begin prod = 16'h0;   e = 1'b1; end
    endcase
    m = CHECK_P && !e && (prod != p[15:0]);
    exp_q.push_back({e, m, prod});

    w = 0;
    while (!req_ready && w < 20) begin step(); w++; end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_a = a; req_b = b;
    step();
    req_valid = 1'b0; req_a = 8'h00; req_b = 8'h00;
    chk("load_m_enable", {31'd0, mul_enable}, 32'd1);
    chk("load_m_inbus", {24'd0, mul_inbus}, {24'd0, a});
    step();
    chk("load_q_enable", {31'd0, mul_enable}, 32'd0);
    chk("load_q_inbus", {24'd0, mul_inbus}, {24'd0, b});
    step();
    c = 3;
    chk("wait_inbus", {24'd0, mul_inbus}, {24'd0, b});
    repeat (dly) begin step(); c++; end
    if (mode <= 1) begin
      mul_done = 1'b1; mul_outbus = prod[15:8];
      step();
      mul_outbus = prod[7:0];
      step();
      mul_done = 1'b0; mul_outbus = 8'h00;
      c += 2;
      chk("done_latency", c, 5 + dly);
    end else if (mode == 3) begin
      mul_done = 1'b1; mul_outbus = 8'h12;
      step();
      mul_done = 1'b0; mul_outbus = 8'h00;
      step();
      c += 2;
    end else begin
      while (!rsp_valid && c < 60) begin step(); c++; end
      chk("timeout_latency", c, 3 + TO);
    end
    chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_product_lit", {16'd0, rsp_product}, {16'd0, lit_prod});
    chk("rsp_err_lit", {31'd0, rsp_err}, {31'd0, lit_err});
    chk("rsp_mismatch_lit", {31'd0, rsp_mismatch}, {31'd0, lit_mism});
    repeat (hold) begin
      step();
      chk("rsp_valid_held", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_product_held", {16'd0, rsp_product}, {16'd0, lit_prod});
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    chk("req_ready_return", {31'd0, req_ready}, 32'd1);
  endtask

  // driver
  initial begin
    rst = 1'b1; req_valid = 1'b0; req_a = 8'h00; req_b = 8'h00;
    rsp_ready = 1'b0; mul_done = 1'b0; mul_outbus = 8'h00;
    step(); step();
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_outputs", {7'd0, rsp_valid, rsp_product, rsp_err, rsp_mismatch, mul_enable, mul_inbus}, 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    run_txn(8'hFD, 8'h05, 0, 8'h00, 8'h00, 0, 0, 16'hFFF1, 1'b0, 1'b0);
    run_txn(8'h80, 8'h80, 0, 8'h00, 8'h00, 2, 1, 16'h4000, 1'b0, 1'b0);
    run_txn(8'h7F, 8'h80, 0, 8'h00, 8'h00, 0, 0, 16'hC080, 1'b0, 1'b0);
    run_txn(8'h11, 8'h22, 2, 8'h00, 8'h00, 0, 0, 16'h0000, 1'b1, 1'b0);
    run_txn(8'h02, 8'h03, 3, 8'h00, 8'h00, 0, 0, 16'h0000, 1'b1, 1'b0);
    run_txn(8'h03, 8'h05, 1, 8'h00, 8'h0E, 0, 0, 16'h000E, 1'b0, 1'b1);
    run_txn(8'h05, 8'h06, 0, 8'h00, 8'h00, TO - 1, 0, 16'h001E, 1'b0, 1'b0);

    // reset while waiting for done: the transaction must vanish
    req_valid = 1'b1; req_a = 8'h21; req_b = 8'h43;
    step();
    req_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    step();
    chk("mid_rst_enable", {31'd0, mul_enable}, 32'd0);
    chk("mid_rst_inbus", {24'd0, mul_inbus}, 32'd0);
    chk("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    step();
    chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);

    run_txn(8'hF9, 8'h09, 0, 8'h00, 8'h00, 1, 5, 16'hFFC1, 1'b0, 1'b0);

    // stray done pulses while idle
    mul_done = 1'b1; mul_outbus = 8'h55;
    step(); step();
    mul_done = 1'b0; mul_outbus = 8'h00;
    for (int i = 0; i < 3; i++) begin
      chk("stray_req_ready", {31'd0, req_ready}, 32'd1);
      chk("stray_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("stray_enable", {31'd0, mul_enable}, 32'd0);
      step();
    end

    chk("exp_q_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
